// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts one byte plus odd parity out on device clock edges and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       done_out,
  output logic       ack_ok,
  output logic       error_out
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE} state_t;

  state_t           state;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       bitcnt;
  logic [7:0]       byte_r;
  logic             parity_r;
  logic             ready_r, clk_dl_r, data_dl_r, done_r, ack_r, error_r;
  logic             clk_p0, clk_p1, clk_p2, dat_p0, dat_p1;
  logic             fall;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous synced clock
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk_in;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= ps2_data_in;
      dat_p1 <= dat_p0;
    end
  end

  assign fall = clk_p2 & ~clk_p1;

  always_ff @(posedge clk_in) begin
    if (valid_in && ready_r) begin
      byte_r   <= data_in;
      parity_r <= odd_parity(data_in);
    end
  end

  always_ff @(posedge clk_in) begin
    done_r  <= 1'b0;
    error_r <= 1'b0;
    if (!rst_in) begin
      state     <= IDLE;
      ready_r   <= 1'b1;
      clk_dl_r  <= 1'b0;
      data_dl_r <= 1'b0;
      ack_r     <= 1'b0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bitcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            state    <= INHIBIT;
            ready_r  <= 1'b0;
            clk_dl_r <= 1'b1;
            inh_cnt  <= '0;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          // data is pulled low one cycle early so it lands while clock is still held
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) data_dl_r <= 1'b1;
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            state    <= REQ;
            clk_dl_r <= 1'b0;
            to_cnt   <= '0;
            bitcnt   <= '0;
          end
        end
        default: begin
          if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            ready_r   <= 1'b1;
            clk_dl_r  <= 1'b0;
            data_dl_r <= 1'b0;
            ack_r     <= 1'b0;
            error_r   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            case (state)
              REQ: begin
                if (fall) begin
                  bitcnt    <= 4'd1;
                  data_dl_r <= ~byte_r[0];
                  state     <= SHIFT;
                end
              end
              SHIFT: begin
                if (fall) begin
                  bitcnt <= bitcnt + 1'b1;
                  case (bitcnt)
                    4'd8:    data_dl_r <= ~parity_r;
                    4'd9:    data_dl_r <= 1'b0;
                    4'd10: begin
                      ack_r <= ~dat_p1;
                      state <= WAIT_IDLE;
                    end
                    default: data_dl_r <= ~byte_r[bitcnt[2:0]];
                  endcase
                end
              end
              WAIT_IDLE: begin
                if (clk_p1 && dat_p1) begin
                  done_r  <= 1'b1;
                  state   <= IDLE;
                  ready_r <= 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign ready_out          = ready_r;
  assign ps2_clk_drive_low  = clk_dl_r;
  assign ps2_data_drive_low = data_dl_r;
  assign done_out           = done_r;
  assign ack_ok             = ack_r;
  assign error_out          = error_r;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the mouse (e.g. 0xF4 enable data reporting, 0xFF reset) over the same two-wire open-drain bus the mouse receiver listens on.
- Sits beside the mouse receiver. It inhibits the bus, issues request-to-send, shifts data out on device-generated clock edges, checks the device ACK, then returns the bus to idle.
- The top level maps the drive-low outputs onto tri-state pads.

Parameters:
- INHIBIT_CYCLES, 10000: clk_in cycles the PS/2 clock is held low before request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clk_in cycles from end of inhibit to ACK sampled (15 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low (0 = reset)
- data_in  input  8  command byte to send
- valid_in  input  1  request to send data_in; accepted only when ready_out=1
- ready_out  output  1  high when idle and able to accept a byte
- ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous)
- ps2_data_in  input  1  raw PS/2 data pin level (asynchronous)
- ps2_clk_drive_low  output  1  1 = pull PS/2 clock low, 0 = release
- ps2_data_drive_low  output  1  1 = pull PS/2 data low, 0 = release
- done_out  output  1  one-cycle pulse when a transfer completes and the bus is idle
- ack_ok  output  1  valid with done_out; 1 = device ACK seen (data low at 11th falling edge); held until next done_out
- error_out  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst_in=0 at posedge): state IDLE; ready_out=1; both drive_low=0; done_out=0; error_out=0; ack_ok=0; synchronizer flops=1; counters=0. Reset mid-transfer releases both lines on that edge. No done or error pulse.
- Input sync: ps2_clk_in and ps2_data_in each pass through 2 flops. A falling edge is detected when prev_sync=1 and sync=0. The detected edge lags the pin by 2-3 cycles.
- Latch: on valid_in=1 with ready_out=1, capture data_in and compute odd parity (parity = ~^data_in). valid_in while busy is ignored.
- IDLE: both lines released. On accept, go to INHIBIT next cycle; ready_out drops the same cycle.
- INHIBIT:
  - clk_drive_low=1 for INHIBIT_CYCLES cycles.
  - data_drive_low=1 asserted on the last INHIBIT cycle, so data goes low while clock is still low.
  - Then go to REQ; timeout counter starts at 0.
- REQ: clk released, data held low (start bit). Wait for a synced clock falling edge. Falling edge counter bitcnt=0.
- SHIFT: on each falling edge bitcnt increments and data_drive_low updates on the same cycle the edge is detected.
  - Edges 1-8: data_drive_low = ~byte[bitcnt-1], LSB first.
  - Edge 9: data_drive_low = ~parity.
  - Edge 10: data_drive_low=0 (stop bit, line released).
  - Edge 11: sample synced data; ack_ok = (data_sync==0); go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clk=1 and synced data=1 on the same cycle, then pulse done_out, go to IDLE, ready_out=1 next cycle.
- Timeout:
  - Counter runs from REQ through WAIT_IDLE and is checked on every cycle.
  - Reaching TIMEOUT_CYCLES aborts: both lines released, error_out pulse, ack_ok=0, IDLE.
  - No done_out on abort.
  - Timeout takes priority over a simultaneous falling edge.
- Clock-low during INHIBIT: device edges are ignored (no edge detection outside REQ/SHIFT).
- Missing ACK (data high at edge 11): still completes via WAIT_IDLE with done_out and ack_ok=0. This is not an error.
- Counter widths: $clog2(INHIBIT_CYCLES+1) and $clog2(TIMEOUT_CYCLES+1); bitcnt is 4 bits. No wrap occurs within one transfer.
- Never drive a line high. Only drive-low or release.

Test Plan:
- Send 0xF4 with INHIBIT_CYCLES=100 and device model clock period 1000 ns (clk_in 10 ns):
  - clk_drive_low high for 100 cycles, then data low.
  - Data bits sampled on device rising edges are 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Model pulls data low on the 11th clock -> done_out pulse, ack_ok=1.
- Send 0xFF: bits all 1, parity 1; ack given -> done_out, ack_ok=1. Then send 0x00 (parity 1) back-to-back after ready_out -> second transfer correct.
- Device gives no ACK (data stays high) -> done_out pulse with ack_ok=0, error_out stays 0.
- Device never clocks after REQ, TIMEOUT_CYCLES=5000 -> error_out pulse exactly 5000 cycles after REQ entry; both drive_low=0; ready_out=1.
- rst_in=0 asserted after edge 5 -> both drive_low=0 on the next cycle, no done_out or error_out; a fresh 0xF4 send afterwards completes correctly.
- valid_in pulsed with 0xAA during a 0xF4 transfer -> ignored; only 0xF4 bits appear on the bus and one done_out pulse occurs.
